// File: rtl/fifo_pointer_controller.sv
// Pointer and flag controller for a single-clock FIFO driving an external
// dual-port RAM. Gray pointers are exported for reuse in a dual-clock variant.
module fifo_pointer_controller #(
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_request,
  input  logic          read_request,
  input  logic          clear_errors,
  output logic          write_enable,
  output logic [AW-1:0] write_address,
  output logic          read_enable,
  output logic [AW-1:0] read_address,
  output logic [AW:0]   write_pointer_gray,
  output logic [AW:0]   read_pointer_gray,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] FULL_MASK = (AW+1)'(3 << (AW - 1));
  localparam logic [AW:0] AF_LVL    = (AW+1)'(ALMOST_FULL_LEVEL);
  localparam logic [AW:0] AE_LVL    = (AW+1)'(ALMOST_EMPTY_LEVEL);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0]   r_wptr, r_rptr, r_wgray, r_rgray;
  logic [LW-1:0] r_level;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_unf;

  logic          w_wr_acc, w_rd_acc;
  logic [AW:0]   w_wptr_nxt, w_rptr_nxt;
  logic [AW:0]   w_wgray_nxt, w_rgray_nxt, w_level_nxt;

  // Acceptance looks only at registered flags; reset masks both strobes.
  assign w_wr_acc = write_request && !r_full && !reset;
  assign w_rd_acc = read_request && !r_empty && !reset;

  assign w_wptr_nxt  = r_wptr + (AW+1)'(w_wr_acc);
  assign w_rptr_nxt  = r_rptr + (AW+1)'(w_rd_acc);
  assign w_wgray_nxt = bin2gray(w_wptr_nxt);
  assign w_rgray_nxt = bin2gray(w_rptr_nxt);
  assign w_level_nxt = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_wgray <= '0;
      r_rgray <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_wgray <= w_wgray_nxt;
      r_rgray <= w_rgray_nxt;
      r_level <= LW'(w_level_nxt);
      r_full  <= (w_wgray_nxt ^ w_rgray_nxt) == FULL_MASK;
      r_empty <= w_wgray_nxt == w_rgray_nxt;
      r_af    <= w_level_nxt >= AF_LVL;
      r_ae    <= w_level_nxt <= AE_LVL;
      r_ovf   <= (write_request && r_full) || (r_ovf && !clear_errors);
      r_unf   <= (read_request && r_empty) || (r_unf && !clear_errors);
    end
  end

  assign write_enable       = w_wr_acc;
  assign read_enable        = w_rd_acc;
  assign write_address      = r_wptr[AW-1:0];
  assign read_address       = r_rptr[AW-1:0];
  assign write_pointer_gray = r_wgray;
  assign read_pointer_gray  = r_rgray;
  assign level              = r_level;
  assign full               = r_full;
  assign empty              = r_empty;
  assign almost_full        = r_af;
  assign almost_empty       = r_ae;
  assign overflow           = r_ovf;
  assign underflow          = r_unf;

endmodule

// File: tb/tb_fifo_pointer_controller.sv
// Bench for fifo_pointer_controller: directed steps plus random traffic
// against a count/queue reference model.
module tb_fifo_pointer_controller;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write_request = 1'b0;
  logic          read_request = 1'b0;
  logic          clear_errors = 1'b0;
  logic          write_enable, read_enable;
  logic [AW-1:0] write_address, read_address;
  logic [AW:0]   write_pointer_gray, read_pointer_gray;
  logic [LW-1:0] level;
  logic          full, empty, almost_full, almost_empty;
  logic          overflow, underflow;

  fifo_pointer_controller #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .write_request      (write_request),
    .read_request       (read_request),
    .clear_errors       (clear_errors),
    .write_enable       (write_enable),
    .write_address      (write_address),
    .read_enable        (read_enable),
    .read_address       (read_address),
    .write_pointer_gray (write_pointer_gray),
    .read_pointer_gray  (read_pointer_gray),
    .level              (level),
    .full               (full),
    .empty              (empty),
    .almost_full        (almost_full),
    .almost_empty       (almost_empty),
    .overflow           (overflow),
    .underflow          (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: total accepted writes/reads since reset
  int          wcnt = 0;
  int          rcnt = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;
  int          addrq[$];
  logic [AW:0] prev_wg = '0;
  logic [AW:0] prev_rg = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] gray_of(input int cnt);
    logic [AW:0] p;
    p = (AW+1)'(cnt % (2 * DEPTH));
    return p ^ (p >> 1);
  endfunction

  task automatic step(input bit wr, input bit rd, input bit clr,
                      input bit rst);
    int  lvl;
    bit  ewe, ere;
    logic [AW:0] ewg, erg;
    write_request = wr;
    read_request  = rd;
    clear_errors  = clr;
    reset         = rst;
    #1;
    lvl = wcnt - rcnt;
    ewe = wr && (lvl != DEPTH) && !rst;
    ere = rd && (lvl != 0) && !rst;
    check("write_enable", write_enable, ewe);
    check("read_enable", read_enable, ere);
    if (ewe) check("write_address", write_address, wcnt % DEPTH);
    if (ere) check("read_address", read_address, addrq[0]);
    if (rst) begin
      wcnt = 0; rcnt = 0; m_ovf = 0; m_unf = 0;
      addrq.delete();
    end else begin
      m_ovf = (wr && lvl == DEPTH) || (m_ovf && !clr);
      m_unf = (rd && lvl == 0) || (m_unf && !clr);
      if (ewe) begin addrq.push_back(wcnt % DEPTH); wcnt++; end
      if (ere) begin void'(addrq.pop_front()); rcnt++; end
    end
    @(posedge clk);
    #1;
    lvl = wcnt - rcnt;
    ewg = gray_of(wcnt);
    erg = gray_of(rcnt);
    check("level", level, lvl);
    check("full", full, lvl == DEPTH);
    check("empty", empty, lvl == 0);
    check("almost_full", almost_full, lvl >= DEPTH - 2);
    check("almost_empty", almost_empty, lvl <= 2);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    check("write_pointer_gray", write_pointer_gray, ewg);
    check("read_pointer_gray", read_pointer_gray, erg);
    if (!rst) begin
      check("wgray_hamming", $countones(write_pointer_gray ^ prev_wg) <= 1, 1);
      check("rgray_hamming", $countones(read_pointer_gray ^ prev_rg) <= 1, 1);
    end
    prev_wg = write_pointer_gray;
    prev_rg = read_pointer_gray;
  endtask

  initial begin
    int wp, rp;
    step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    // fill to 16
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0);
    check("plan_full_gray", write_pointer_gray, 5'b11000);
    check("plan_full_level", level, 16);
    // write on full: overflow, sticky, then cleared
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("plan_ovf_sticky", overflow, 1'b1);
    step(0, 0, 1, 0);
    check("plan_ovf_clear", overflow, 1'b0);
    // simultaneous on full: read at 0 accepted, write rejected
    step(1, 1, 0, 0);
    check("plan_full_rw_level", level, 15);
    check("plan_full_rw_ovf", overflow, 1'b1);
    // simultaneous on empty
    step(0, 0, 1, 1);
    step(1, 1, 0, 0);
    check("plan_empty_rw_level", level, 1);
    check("plan_empty_rw_unf", underflow, 1'b1);
    // clear and set in same cycle: set wins
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("plan_set_beats_clear", underflow, 1'b1);
    step(0, 0, 1, 0);
    // random traffic with alternating bias so both flags and wraps occur
    for (int i = 0; i < 400; i++) begin
      int seg;
      seg = i / 40;
      wp = (seg % 2 == 0) ? 70 : 30;
      rp = (seg % 2 == 0) ? 35 : 75;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 15) == 0, 0);
    end
    // reset mid-operation with a write pending
    step(0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    check("plan_ten_level", level, 10);
    step(1, 0, 0, 1);
    check("plan_rst_level", level, 0);
    check("plan_rst_empty", empty, 1'b1);
    check("plan_rst_wgray", write_pointer_gray, 0);
    check("plan_rst_ovf", overflow, 1'b0);
    step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_pointer_controller.md
# fifo_pointer_controller

Pointer and flag controller for a single-clock FIFO built on the team's gray-coded counters. It arbitrates write and read requests against the buffer state and drives the address and enable lines of an external dual-port RAM. It also publishes full, empty, almost-full, almost-empty, fill level and sticky error flags. Gray-coded pointers are exported so that a later dual-clock variant can reuse the same flag logic unchanged.

## Interface
- DEPTH, 16, number of entries; must be a power of two, at least 2; AW = $clog2(DEPTH)
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserted when level >= this value
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserted when level <= this value
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- write_request  input  1  producer wants to push one entry this cycle
- read_request  input  1  consumer wants to pop one entry this cycle
- clear_errors  input  1  clears the overflow and underflow flags
- write_enable  output  1  RAM write strobe (accepted write)
- write_address  output  AW  RAM write address
- read_enable  output  1  RAM read strobe (accepted read)
- read_address  output  AW  RAM read address
- write_pointer_gray  output  AW+1  gray-coded write pointer, registered
- read_pointer_gray  output  AW+1  gray-coded read pointer, registered
- level  output  $clog2(DEPTH+1)  number of stored entries
- full, empty, almost_full, almost_empty  output  1 each  status flags
- overflow, underflow  output  1 each  sticky error flags

## Operation
- State: binary write and read pointers, each AW+1 bits, wrapping modulo 2*DEPTH. Gray outputs are the registered bin-to-gray conversion of each pointer.
- Accepted write = write_request && !full. Accepted read = read_request && !empty. Evaluation uses the registered flags only; there is no same-cycle bypass.
- write_enable and read_enable are combinational from the accepted conditions.
- write_address = write pointer [AW-1:0]; read_address = read pointer [AW-1:0].
- Each accepted operation increments its pointer by 1 at the clock edge.
- empty: gray pointers are equal.
- full: write_pointer_gray equals read_pointer_gray with its top two bits inverted.
- level = write pointer − read pointer, modulo 2*DEPTH. It is never greater than DEPTH.
- Simultaneous request when neither full nor empty: both are accepted and level is unchanged.
- Simultaneous request when full: the read is accepted and the write is rejected. Level drops by 1 and overflow is set.
- Simultaneous request when empty: the write is accepted and the read is rejected. Level rises by 1 and underflow is set.
- overflow is set on any cycle with write_request && full. underflow is set on any cycle with read_request && empty.
- clear_errors clears both sticky flags. If a set condition and clear_errors occur in the same cycle, the set wins.
- Data storage and read latency belong to the RAM. This controller never touches data.

## Timing
- Reset values: both pointers 0, gray outputs 0, level 0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- While reset is high, write_enable=0 and read_enable=0 regardless of requests.
- Reset asserted mid-operation discards all contents on the next edge. Requests in that cycle are ignored and no error flags are set.
- Flags, level and gray pointers are registered. They reflect an accepted operation one cycle after its strobe.
- The write strobe and write address are valid in the same cycle as an accepted write_request.
- The read address is issued in the cycle of the accepted read. Data appears after the RAM latency.
- Wrap-around: pointer value 2*DEPTH−1 increments to 0. Each gray pointer changes exactly one bit per increment, including at the wrap.
- Back-to-back operations are allowed every cycle. Sustained throughput is 1 write and 1 read per cycle.

## Test plan
- Reset then 16 consecutive writes (DEPTH=16) -> write_address runs 0..15. After the 16th write: full=1, level=16, almost_full=1, write_pointer_gray=5'b11000.
- Full FIFO, write_request for 1 cycle -> write_enable=0, pointers unchanged, overflow=1 next cycle and stays 1. clear_errors pulse -> overflow=0.
- Empty FIFO, read_request and write_request together -> write accepted, read rejected. Next cycle: level=1, empty=0, underflow=1.
- Full FIFO, read_request and write_request together -> read_enable=1 at read_address 0, write_enable=0. Next cycle: level=15, full=0, overflow=1.
- Random interleave of 100 writes and reads with both pointers passing the wrap at least twice -> level matches the scoreboard every cycle. Each gray output has Hamming distance ≤1 between cycles. Read address order matches write order.
- After 10 writes, assert reset for 1 cycle with write_request=1 -> next cycle: level=0, empty=1, all pointers 0, no error flags, no write accepted during reset.
